aoi_sweep_controller: RTL and testbench

Self-checking sequencer for the four-input AOI gate (inputs a,b,c,d; outputs e,f,g).
- On a start pulse it drives all 16 input combinations into the gate in order and waits a programmable settle time for each.
- It samples e/f/g and compares them against a golden model, then reports pass/fail, the mismatch count and the first failing vector.
- It sits beside the gate instance on the lab board/top level and replaces the free-running toggling stimulus with a clocked, checkable sweep.

---
 rtl/aoi_sweep_pkg.sv | 26 ++
 rtl/aoi_golden_model.sv | 11 +
 rtl/aoi_sweep_controller.sv | 157 +++++++++++++++
 tb/tb_aoi_sweep_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aoi_sweep_pkg.sv
// Shared types, constants and the AOI golden function for the sweep controller.
package aoi_sweep_pkg;

   // Sweep sequencer states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   localparam int unsigned VEC_COUNT = 16;
   localparam int unsigned VEC_W     = $clog2(VEC_COUNT);
   localparam logic [3:0]  LAST_VEC  = 4'hF;

   // Expected {e,f,g} of the AOI gate for vector {a,b,c,d}
   function automatic logic [2:0] aoi_golden(input logic [3:0] v);
      logic ab;
      logic cd;
      ab = v[3] & v[2];
      cd = v[1] & v[0];
      return {ab, cd, ~(ab | cd)};
   endfunction

endpackage

// File: rtl/aoi_golden_model.sv
// Combinational golden model of the four-input AOI gate.
module aoi_golden_model
   import aoi_sweep_pkg::*;
(
   input  logic [3:0] vec_i,
   output logic [2:0] efg_o
);

   assign efg_o = aoi_golden(vec_i);

endmodule

// File: rtl/aoi_sweep_controller.sv
// Clocked sweep of all 16 AOI input vectors with golden-model checking.
module aoi_sweep_controller
   import aoi_sweep_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned SET_W         = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       e_in,
   input  logic       f_in,
   input  logic       g_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       fail_valid,
   output logic [3:0] fail_vec
);

   // Terminal value of the settle counter; unused when SETTLE_CYCLES is 0
   localparam logic [SET_W-1:0] SET_LAST =
      SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [SET_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         abcd_q, abcd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [4:0]         err_q, err_d;
   logic               fv_q, fv_d;
   logic [3:0]         fvec_q, fvec_d;
   logic [2:0]         exp_efg;
   logic               mismatch;

   aoi_golden_model u_golden (
      .vec_i (vec_q),
      .efg_o (exp_efg)
   );

   assign mismatch = ({e_in, f_in, g_in} != exp_efg);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counters, result bookkeeping and registered output values
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               fvec_d  = '0;
            end
         end
         S_DRIVE: begin
            cnt_d   = '0;
            state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == SET_LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + SET_W'(1);
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               err_d = err_q + 5'd1;
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = 4'(vec_q);
               end
            end
            if (4'(vec_q) == LAST_VEC) begin
               state_d = S_DONE;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               state_d = S_DRIVE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Gate inputs load on entry to DRIVE and hold until the vector's CHECK ends
      unique case (state_d)
         S_DRIVE:           abcd_d = 4'(vec_d);
         S_SETTLE, S_CHECK: abcd_d = abcd_q;
         default:           abcd_d = 4'h0;
      endcase

      busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_d == 5'd0);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q  <= '0;
         cnt_q  <= '0;
         abcd_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
         fv_q   <= 1'b0;
         fvec_q <= '0;
      end else begin
         vec_q  <= vec_d;
         cnt_q  <= cnt_d;
         abcd_q <= abcd_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
         err_q  <= err_d;
         fv_q   <= fv_d;
         fvec_q <= fvec_d;
      end
   end

   assign a          = abcd_q[3];
   assign b          = abcd_q[2];
   assign c          = abcd_q[1];
   assign d          = abcd_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_aoi_sweep_controller.sv
// Directed bench for aoi_sweep_controller: default settle instance and a zero-settle instance.
module tb_aoi_sweep_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start0;
   logic [1:0] mode, mode0;   // 0: real gate, 1: e stuck at 0, 2: g inverted

   logic       a, b, c, d, e_in, f_in, g_in, busy, done, pass, fail_valid;
   logic [4:0] err_count;
   logic [3:0] fail_vec;

   logic       a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0, fail_valid0;
   logic [4:0] err_count0;
   logic [3:0] fail_vec0;

   int checks = 0;
   int errors = 0;

   logic [3:0] seq [0:15];
   int         nvec;
   logic [3:0] snap_abcd;
   logic [4:0] snap_err;

   // Bench-side AOI gates with optional fault injection
   assign e_in = (mode == 2'd1) ? 1'b0 : (a & b);
   assign f_in = c & d;
   assign g_in = (mode == 2'd2) ? ((a & b) | (c & d)) : ~((a & b) | (c & d));
   assign e0   = (mode0 == 2'd1) ? 1'b0 : (a0 & b0);
   assign f0   = c0 & d0;
   assign g0   = (mode0 == 2'd2) ? ((a0 & b0) | (c0 & d0)) : ~((a0 & b0) | (c0 & d0));

   aoi_sweep_controller dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a), .b(b), .c(c), .d(d),
      .e_in(e_in), .f_in(f_in), .g_in(g_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_vec(fail_vec)
   );

   aoi_sweep_controller #(.SETTLE_CYCLES(0), .SET_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
      .a(a0), .b(b0), .c(c0), .d(d0),
      .e_in(e0), .f_in(f0), .g_in(g0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
      .fail_valid(fail_valid0), .fail_vec(fail_vec0)
   );

   // Pulse start on dut; n = cycles after acceptance until done (200 = timeout).
   // Optional start poke at cycle poke_at and reset at cycle rst_at.
   task automatic run_sweep(input int poke_at, input int rst_at, output int n);
      logic [3:0] last;
      bit         have;
      last = 4'h0; have = 1'b0; nvec = 0; n = 200;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (busy && (!have || {a, b, c, d} != last)) begin
            if (nvec < 16) seq[nvec] = {a, b, c, d};
            nvec++;
            last = {a, b, c, d};
            have = 1'b1;
         end
         if (done) begin n = k; break; end
         start = (k == poke_at);
         if (k == rst_at) begin
            snap_abcd = {a, b, c, d};
            snap_err  = err_count;
            rst = 1'b1;
            n = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 2'd0; mode0 = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec} !== 17'h0) begin
         errors++; $display("FAIL reset_dut outputs=%h want 0", {a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec});
      end
      checks++;
      if ({a0, b0, c0, d0, busy0, done0, pass0, err_count0, fail_valid0, fail_vec0} !== 17'h0) begin
         errors++; $display("FAIL reset_dut0 outputs=%h want 0", {a0, b0, c0, d0, busy0, done0, pass0, err_count0, fail_valid0, fail_vec0});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_hold done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_good_sweep();
      int n;
      mode = 2'd0;
      run_sweep(-1, -1, n);
      checks++; if (n !== 65) begin errors++; $display("FAIL good_latency got=%0d want 65", n); end
      checks++; if (nvec !== 16) begin errors++; $display("FAIL good_nvec got=%0d want 16", nvec); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (seq[i] !== 4'(i)) begin errors++; $display("FAIL good_order[%0d] got=%b want=%b", i, seq[i], 4'(i)); end
      end
      checks++;
      if ({pass, err_count, fail_valid, fail_vec, busy} !== {1'b1, 5'd0, 1'b0, 4'd0, 1'b0}) begin
         errors++; $display("FAIL good_result pass=%b err=%0d fv=%b fvec=%b busy=%b want 1 0 0 0000 0", pass, err_count, fail_valid, fail_vec, busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, pass, a, b, c, d} !== 6'b110000) begin
         errors++; $display("FAIL done_hold done=%b pass=%b abcd=%b want 1 1 0000", done, pass, {a, b, c, d});
      end
   endtask

   task automatic test_e_stuck();
      int n;
      mode = 2'd1;
      run_sweep(-1, -1, n);
      checks++; if (n !== 65) begin errors++; $display("FAIL estuck_latency got=%0d want 65", n); end
      checks++; if (err_count !== 5'd4) begin errors++; $display("FAIL estuck_err got=%0d want 4", err_count); end
      checks++;
      if ({fail_valid, fail_vec, pass} !== {1'b1, 4'b1100, 1'b0}) begin
         errors++; $display("FAIL estuck_fail fv=%b fvec=%b pass=%b want 1 1100 0", fail_valid, fail_vec, pass);
      end
   endtask

   task automatic test_g_inverted();
      int n;
      mode = 2'd2;
      run_sweep(-1, -1, n);
      checks++; if (err_count !== 5'd16) begin errors++; $display("FAIL ginv_err got=%0d want 16", err_count); end
      checks++;
      if ({fail_valid, fail_vec, pass} !== {1'b1, 4'b0000, 1'b0}) begin
         errors++; $display("FAIL ginv_fail fv=%b fvec=%b pass=%b want 1 0000 0", fail_valid, fail_vec, pass);
      end
   endtask

   task automatic test_start_ignored();
      int n;
      mode = 2'd0;
      run_sweep(22, -1, n);   // cycle 22 is SETTLE of vector 5
      checks++; if (n !== 65) begin errors++; $display("FAIL poke_latency got=%0d want 65", n); end
      checks++; if (nvec !== 16) begin errors++; $display("FAIL poke_nvec got=%0d want 16", nvec); end
      checks++;
      if ({pass, err_count, fail_valid} !== {1'b1, 5'd0, 1'b0}) begin
         errors++; $display("FAIL poke_result pass=%b err=%0d fv=%b want 1 0 0", pass, err_count, fail_valid);
      end
   endtask

   task automatic test_rst_mid();
      int n;
      mode = 2'd2;
      run_sweep(-1, 32, n);   // cycle 32 is CHECK of vector 7
      checks++;
      if ({snap_abcd, snap_err} !== {4'b0111, 5'd7}) begin
         errors++; $display("FAIL rstmid_pre abcd=%b err=%0d want 0111 7", snap_abcd, snap_err);
      end
      @(negedge clk);
      checks++;
      if ({a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec} !== 17'h0) begin
         errors++; $display("FAIL rstmid_clear outputs=%h want 0", {a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec});
      end
      rst = 1'b0;
      mode = 2'd0;
      run_sweep(-1, -1, n);
      checks++; if (n !== 65) begin errors++; $display("FAIL rstmid_latency got=%0d want 65", n); end
      checks++; if (nvec !== 16) begin errors++; $display("FAIL rstmid_nvec got=%0d want 16", nvec); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rstmid_pass got=%b want 1", pass); end
   endtask

   task automatic test_zero_settle();
      int n;
      mode0 = 2'd1;
      n = 100;
      @(negedge clk); start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done0) begin n = k; break; end
      end
      checks++; if (n !== 33) begin errors++; $display("FAIL zero_latency got=%0d want 33", n); end
      checks++;
      if ({err_count0, fail_vec0, pass0} !== {5'd4, 4'b1100, 1'b0}) begin
         errors++; $display("FAIL zero_estuck err=%0d fvec=%b pass=%b want 4 1100 0", err_count0, fail_vec0, pass0);
      end
      // restart from DONE with a good gate
      mode0 = 2'd0;
      n = 100;
      @(negedge clk); start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      @(negedge clk);
      checks++;
      if ({done0, busy0, err_count0, fail_valid0, fail_vec0} !== {1'b0, 1'b1, 5'd0, 1'b0, 4'd0}) begin
         errors++; $display("FAIL zero_restart done=%b busy=%b err=%0d fv=%b fvec=%b want 0 1 0 0 0000", done0, busy0, err_count0, fail_valid0, fail_vec0);
      end
      for (int k = 2; k <= 100; k++) begin
         @(negedge clk);
         if (done0) begin n = k; break; end
      end
      checks++; if (n !== 33) begin errors++; $display("FAIL zero_rerun_latency got=%0d want 33", n); end
      checks++;
      if ({pass0, err_count0} !== {1'b1, 5'd0}) begin
         errors++; $display("FAIL zero_rerun_result pass=%b err=%0d want 1 0", pass0, err_count0);
      end
   endtask

   initial begin
      test_reset();
      test_good_sweep();
      test_e_stuck();
      test_g_inverted();
      test_start_ignored();
      test_rst_mid();
      test_zero_settle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
